cmd_tag_allocator: RTL and testbench

Parametrised command-tag allocator, successor to the fixed TAG_COUNT=256 / INVALID_TAG=0 scheme. It issues unique CAPI command tags to requesting CUs and records the cu_id that owns each tag. On response, it returns the owner cu_id and recycles the tag. It sits in afu_control between the command arbiter and the command/response buffers, and detects double-free and invalid-tag release.

---
 rtl/cmd_tag_allocator_pkg.sv | 23 ++
 rtl/cmd_tag_allocator_free_tag_fifo.sv | 53 +++++
 rtl/cmd_tag_allocator.sv | 134 +++++++++++++
 tb/tb_cmd_tag_allocator.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_tag_allocator_pkg.sv
// Shared types and reserved values for the command-tag allocator and its users.
package cmd_tag_allocator_pkg;

  localparam int unsigned TAG_COUNT   = 256;
  localparam int unsigned TAG_WIDTH   = $clog2(TAG_COUNT);
  localparam int unsigned CU_ID_RANGE = 8;

  typedef logic [0:TAG_WIDTH-1]   tag_t;
  typedef logic [CU_ID_RANGE-1:0] cu_id_t;

  localparam tag_t   INVALID_TAG = '0;
  localparam cu_id_t INVALID_ID  = '0;

  typedef struct packed {
    logic   valid;
    tag_t   tag;
    cu_id_t cu_id;
  } tag_rsp_t;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/cmd_tag_allocator_free_tag_fifo.sv
// Show-ahead synchronous FIFO holding the currently free command tags.
module free_tag_fifo #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   level;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (level == '0);
    full    = (level == (PTR_W+1)'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && !full;
    head    = mem[rd_ptr];
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + (PTR_W+1)'(1);
        2'b01:   level <= level - (PTR_W+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/cmd_tag_allocator.sv
// Issues unique command tags, records the owning cu_id, recycles tags on response
// and flags releases of tags that are not outstanding.
module cmd_tag_allocator #(
  parameter int unsigned TAG_COUNT   = cmd_tag_allocator_pkg::TAG_COUNT,
  parameter int unsigned TAG_WIDTH   = $clog2(TAG_COUNT),
  parameter int unsigned CU_ID_RANGE = cmd_tag_allocator_pkg::CU_ID_RANGE,
  parameter int unsigned INVALID_TAG = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enabled,
  input  logic                   alloc_valid,
  input  logic [CU_ID_RANGE-1:0] alloc_cu_id,
  output logic                   alloc_ready,
  output logic [TAG_WIDTH-1:0]   alloc_tag,
  input  logic                   release_valid,
  input  logic [TAG_WIDTH-1:0]   release_tag,
  output logic                   rsp_valid,
  output logic [TAG_WIDTH-1:0]   rsp_tag,
  output logic [CU_ID_RANGE-1:0] rsp_cu_id,
  output logic                   error_double_free,
  output logic                   init_done,
  output logic [TAG_WIDTH:0]     outstanding_count,
  output logic                   idle
);

  import cmd_tag_allocator_pkg::*;

  localparam logic [TAG_WIDTH-1:0]   NULL_TAG = TAG_WIDTH'(INVALID_TAG);
  localparam logic [TAG_WIDTH-1:0]   LAST_TAG = TAG_WIDTH'(TAG_COUNT - 1);
  localparam logic [CU_ID_RANGE-1:0] NULL_ID  = CU_ID_RANGE'(INVALID_ID);
  localparam logic [TAG_WIDTH:0]     CNT_ONE  = (TAG_WIDTH+1)'(1);

  typedef struct packed {
    logic                   valid;
    logic [TAG_WIDTH-1:0]   tag;
    logic [CU_ID_RANGE-1:0] cu_id;
  } rsp_t;

  logic [0:0]             state;
  logic [TAG_WIDTH-1:0]   init_cnt;
  logic [TAG_COUNT-1:0]   outstanding;
  logic [CU_ID_RANGE-1:0] owner [TAG_COUNT];
  logic [TAG_WIDTH:0]     count;
  rsp_t                   rsp_q;
  logic                   err_q;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [TAG_WIDTH-1:0]   fifo_din;
  logic [TAG_WIDTH-1:0]   fifo_head;
  logic                   alloc_fire;
  logic                   release_ok;

  free_tag_fifo #(
    .DEPTH (TAG_COUNT),
    .WIDTH (TAG_WIDTH)
  ) u_free_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (fifo_din),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Bitmap is read before this cycle's allocation updates it, so releasing the
  // tag being granted right now is reported as a double free.
  always_comb begin
    alloc_ready = (state == ST_RUN) && enabled && !fifo_empty;
    alloc_tag   = alloc_ready ? fifo_head : NULL_TAG;
    alloc_fire  = alloc_valid && alloc_ready;
    release_ok  = release_valid && (release_tag != NULL_TAG) && outstanding[release_tag];
    fifo_pop    = alloc_fire;
    fifo_din    = release_tag;
    fifo_push   = release_ok && !fifo_full;
    if (state == ST_INIT) begin
      fifo_din  = init_cnt;
      fifo_push = !fifo_full;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_INIT;
      init_cnt <= TAG_WIDTH'(1);
    end else if (state == ST_INIT) begin
      init_cnt <= init_cnt + TAG_WIDTH'(1);
      if (init_cnt == LAST_TAG) state <= ST_RUN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outstanding <= '0;
      for (int unsigned i = 0; i < TAG_COUNT; i++) owner[i] <= NULL_ID;
      count <= '0;
      rsp_q <= '{valid: 1'b0, tag: '0, cu_id: NULL_ID};
      err_q <= 1'b0;
    end else begin
      if (release_ok) outstanding[release_tag] <= 1'b0;
      if (alloc_fire) begin
        outstanding[alloc_tag] <= 1'b1;
        owner[alloc_tag]       <= alloc_cu_id;
      end
      case ({alloc_fire, release_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      rsp_q.valid <= release_ok;
      if (release_ok) begin
        rsp_q.tag   <= release_tag;
        rsp_q.cu_id <= owner[release_tag];
      end
      err_q <= release_valid && !release_ok;
    end
  end

  always_comb begin
    rsp_valid         = rsp_q.valid;
    rsp_tag           = rsp_q.tag;
    rsp_cu_id         = rsp_q.cu_id;
    error_double_free = err_q;
    init_done         = (state == ST_RUN);
    outstanding_count = count;
    idle              = init_done && (count == '0);
  end

endmodule

// File: tb/tb_cmd_tag_allocator.sv
// Scoreboard bench for cmd_tag_allocator with an 8-entry tag space.
module tb_cmd_tag_allocator;

  import cmd_tag_allocator_pkg::*;

  localparam int unsigned TC = 8;
  localparam int unsigned TW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enabled = 1'b1;
  logic          alloc_valid = 1'b0;
  logic [7:0]    alloc_cu_id = '0;
  logic          alloc_ready;
  logic [TW-1:0] alloc_tag;
  logic          release_valid = 1'b0;
  logic [TW-1:0] release_tag = '0;
  logic          rsp_valid;
  logic [TW-1:0] rsp_tag;
  logic [7:0]    rsp_cu_id;
  logic          error_double_free;
  logic          init_done;
  logic [TW:0]   outstanding_count;
  logic          idle;

  always #5 clock = ~clock;

  cmd_tag_allocator #(
    .TAG_COUNT (TC)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .enabled           (enabled),
    .alloc_valid       (alloc_valid),
    .alloc_cu_id       (alloc_cu_id),
    .alloc_ready       (alloc_ready),
    .alloc_tag         (alloc_tag),
    .release_valid     (release_valid),
    .release_tag       (release_tag),
    .rsp_valid         (rsp_valid),
    .rsp_tag           (rsp_tag),
    .rsp_cu_id         (rsp_cu_id),
    .error_double_free (error_double_free),
    .init_done         (init_done),
    .outstanding_count (outstanding_count),
    .idle              (idle)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  typedef struct {
    logic          valid;
    logic          err;
    logic [TW-1:0] tag;
    logic [7:0]    cu;
  } exp_t;

  exp_t          exp_q[$];
  logic [TW-1:0] mdl_free[$];
  logic          mdl_out[TC];
  logic [7:0]    mdl_owner[TC];
  int            mdl_count;
  bit            mdl_run;
  logic [TW-1:0] seen_tag;

  task automatic model_reset();
    for (int i = 0; i < TC; i++) begin
      mdl_out[i]   = 1'b0;
      mdl_owner[i] = INVALID_ID;
    end
    mdl_free.delete();
    exp_q.delete();
    mdl_count = 0;
    mdl_run   = 1'b0;
  endtask

  task automatic check_reset_values();
    check_eq("rst_alloc_ready", alloc_ready, 0);
    check_eq("rst_alloc_tag", alloc_tag, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_tag", rsp_tag, 0);
    check_eq("rst_rsp_cu_id", rsp_cu_id, INVALID_ID);
    check_eq("rst_error", error_double_free, 0);
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_count", outstanding_count, 0);
    check_eq("rst_idle", idle, 0);
  endtask

  // Called #1 after a clock edge; consumes exactly one clock.
  task automatic do_cycle(input bit av, input logic [7:0] cu, input bit rv, input logic [TW-1:0] rt);
    bit            exp_ready;
    bit            grant;
    bit            ok;
    exp_t          e;
    logic [TW-1:0] t;
    alloc_valid   = av;
    alloc_cu_id   = cu;
    release_valid = rv;
    release_tag   = rt;
    #1;
    exp_ready = mdl_run && enabled && (mdl_free.size() > 0);
    check_eq("alloc_ready", alloc_ready, exp_ready);
    if (exp_ready) begin
      check_eq("alloc_tag", alloc_tag, mdl_free[0]);
      seen_tag = alloc_tag;
    end
    grant   = av && exp_ready;
    ok      = rv && (rt != 0) && mdl_out[rt];
    e.valid = ok;
    e.err   = rv && !ok;
    e.tag   = rt;
    e.cu    = mdl_owner[rt];
    exp_q.push_back(e);
    if (ok) begin
      mdl_out[rt] = 1'b0;
      mdl_free.push_back(rt);
      mdl_count--;
    end
    if (grant) begin
      t = mdl_free.pop_front();
      mdl_out[t]   = 1'b1;
      mdl_owner[t] = cu;
      mdl_count++;
    end
    @(posedge clock);
    #1;
    alloc_valid   = 1'b0;
    release_valid = 1'b0;
    e = exp_q.pop_front();
    check_eq("rsp_valid", rsp_valid, e.valid);
    check_eq("error_double_free", error_double_free, e.err);
    if (e.valid) begin
      check_eq("rsp_tag", rsp_tag, e.tag);
      check_eq("rsp_cu_id", rsp_cu_id, e.cu);
    end
    check_eq("outstanding_count", outstanding_count, mdl_count);
    check_eq("idle", idle, mdl_run && (mdl_count == 0));
  endtask

  // Entered #1 after a clock edge with reset just deasserted.
  task automatic run_init();
    int n;
    model_reset();
    check_eq("init_done_low", init_done, 0);
    do_cycle(1'b1, 8'h01, 1'b1, 3'd3);
    n = 1;
    while (!init_done && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    check_eq("init_cycles", n, TC - 1);
    mdl_run = 1'b1;
    for (int i = 1; i < TC; i++) mdl_free.push_back(TW'(i));
    check_eq("idle_after_init", idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [TW-1:0] t11;
    logic [TW-1:0] old_tag;
    int            guard;

    model_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    check_reset_values();
    reset = 1'b0;
    run_init();

    for (int i = 1; i < TC; i++) begin
      do_cycle(1'b1, 8'h05, 1'b0, '0);
      check_eq("scn1_tag_order", seen_tag, i);
    end
    do_cycle(1'b1, 8'h05, 1'b0, '0);
    check_eq("scn1_full_ready", alloc_ready, 0);
    check_eq("scn1_count", outstanding_count, 7);

    do_cycle(1'b1, 8'h05, 1'b1, 3'd2);
    do_cycle(1'b1, 8'h05, 1'b0, '0);
    check_eq("scn4_regrant", seen_tag, 2);

    do_cycle(1'b0, '0, 1'b1, 3'd3);
    check_eq("scn2_cu_id", rsp_cu_id, 8'h05);
    check_eq("scn2_count", outstanding_count, 6);
    do_cycle(1'b1, 8'h05, 1'b0, '0);
    check_eq("scn2_regrant", seen_tag, 3);

    do_cycle(1'b0, '0, 1'b1, 3'd3);
    do_cycle(1'b0, '0, 1'b1, 3'd3);
    check_eq("scn3_double_free", error_double_free, 1);
    check_eq("scn3_count", outstanding_count, 6);
    do_cycle(1'b0, '0, 1'b1, 3'd0);
    check_eq("scn3_invalid_tag", error_double_free, 1);

    enabled = 1'b0;
    do_cycle(1'b1, 8'h09, 1'b1, 3'd4);
    enabled = 1'b1;
    check_eq("disabled_release", rsp_valid, 1);

    do_cycle(1'b0, '0, 1'b1, 3'd2);
    do_cycle(1'b0, '0, 1'b1, 3'd6);
    check_eq("scn5_pre_count", outstanding_count, 3);
    do_cycle(1'b1, 8'h11, 1'b1, 3'd1);
    t11 = seen_tag;
    check_eq("scn5_rsp_cu_id", rsp_cu_id, 8'h05);
    check_eq("scn5_count", outstanding_count, 3);
    check_eq("scn5_granted", t11, 3);
    do_cycle(1'b0, '0, 1'b1, t11);
    check_eq("scn5_new_owner", rsp_cu_id, 8'h11);

    do_cycle(1'b1, 8'h22, 1'b1, mdl_free[0]);
    check_eq("same_tag_error", error_double_free, 1);

    for (int i = 0; i < 60; i++)
      do_cycle(1'($urandom_range(1)), 8'($urandom), 1'($urandom_range(1)), TW'($urandom));

    guard = 0;
    while (mdl_count != 4 && guard < 20) begin
      if (mdl_count < 4) begin
        do_cycle(1'b1, 8'h33, 1'b0, '0);
      end else begin
        for (int i = 1; i < TC; i++) begin
          if (mdl_out[i]) old_tag = TW'(i);
        end
        do_cycle(1'b0, '0, 1'b1, old_tag);
      end
      guard++;
    end
    check_eq("scn6_pre_count", outstanding_count, 4);
    for (int i = 1; i < TC; i++) begin
      if (mdl_out[i]) old_tag = TW'(i);
    end

    reset = 1'b1;
    #1;
    check_reset_values();
    @(posedge clock);
    #1;
    reset = 1'b0;
    run_init();
    do_cycle(1'b0, '0, 1'b1, old_tag);
    check_eq("scn6_late_release", error_double_free, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
